// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg: shared types and constants for the pipeline stall/flush controller
package pipeline_sequencer_pkg;

    typedef logic [31:0] addr_t;
    typedef logic        bool_t;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FLUSH
    } seq_state_t;

    // addi x0, x0, 0 -- what flushed IF/ID and bubbled ID/EX registers hold
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // wide enough for any MEM_TIMEOUT up to 255
    localparam int WAIT_W = 8;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
//   clk, rst : clock, asynchronous active-high reset
//   en       : count this cycle
//   clr      : return to zero (wins over en)
//   count    : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: per-stage enable/flush/bubble control from hazard, branch and memory-wait events
//   clk, rst            : clock, asynchronous active-high reset
//   hazard_stall_in     : load-use stall request
//   branch_taken_in     : EX resolved a taken branch, target on branch_target_in
//   mem_req_in          : MEM stage holds a load/store
//   mem_ready_in        : data memory completes this cycle
//   pc_write_enable_out : PC update enable
//   if_id_enable_out    : IF/ID load enable
//   if_id_flush_out     : clear IF/ID to NOP
//   id_ex_bubble_out    : load NOP into ID/EX
//   pipe_freeze_out     : hold EX/MEM and MEM/WB
//   pc_redirect_out     : next PC comes from redirect_pc_out
//   mem_timeout_out     : sticky memory-wait timeout
//   stall_cycles_out    : saturating count of stalled/flushing cycles
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hazard_stall_in,
    input  logic                  branch_taken_in,
    input  addr_t                 branch_target_in,
    input  logic                  mem_req_in,
    input  logic                  mem_ready_in,
    output logic                  pc_write_enable_out,
    output logic                  if_id_enable_out,
    output logic                  if_id_flush_out,
    output logic                  id_ex_bubble_out,
    output logic                  pipe_freeze_out,
    output logic                  pc_redirect_out,
    output addr_t                 redirect_pc_out,
    output logic                  mem_timeout_out,
    output logic [PERF_WIDTH-1:0] stall_cycles_out
);

    seq_state_t        state, state_n;
    logic [1:0]        flush_cnt, flush_n;
    logic              pend, pend_n;
    addr_t             pend_pc, pend_pc_n;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_req;
    logic              timeout_hit;

    assign wait_req = mem_req_in && !mem_ready_in;

    // wait_cnt holds the wait cycles already elapsed, so +1 counts the current one
    assign timeout_hit = pipe_freeze_out && (int'(wait_cnt) + 1 >= MEM_TIMEOUT);

    // Outputs are gated by rst so an asynchronous reset shows reset values at once,
    // even while inputs are still active.
    always_comb begin
        state_n             = state;
        flush_n             = flush_cnt;
        pend_n              = pend;
        pend_pc_n           = pend_pc;
        pc_write_enable_out = 1'b1;
        if_id_enable_out    = 1'b1;
        if_id_flush_out     = 1'b0;
        id_ex_bubble_out    = 1'b0;
        pipe_freeze_out     = 1'b0;
        pc_redirect_out     = 1'b0;
        redirect_pc_out     = '0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (wait_req) begin
                        pipe_freeze_out     = 1'b1;
                        pc_write_enable_out = 1'b0;
                        if_id_enable_out    = 1'b0;
                        state_n             = MEM_WAIT;
                    end else if (branch_taken_in) begin
                        pc_redirect_out  = 1'b1;
                        redirect_pc_out  = branch_target_in;
                        if_id_flush_out  = 1'b1;
                        id_ex_bubble_out = 1'b1;
                        flush_n          = 2'(FLUSH_DEPTH - 1);
                        state_n          = FLUSH_DEPTH > 1 ? FLUSH : RUN;
                    end else if (hazard_stall_in) begin
                        pc_write_enable_out = 1'b0;
                        if_id_enable_out    = 1'b0;
                        id_ex_bubble_out    = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // only the oldest redirect seen while frozen is kept
                    if (branch_taken_in && !pend) begin
                        pend_n    = 1'b1;
                        pend_pc_n = branch_target_in;
                    end
                    if (!mem_ready_in) begin
                        pipe_freeze_out     = 1'b1;
                        pc_write_enable_out = 1'b0;
                        if_id_enable_out    = 1'b0;
                    end else begin
                        // a pending redirect restarts the full flush; otherwise resume any interrupted one
                        state_n = (pend_n || flush_cnt != 2'd0) ? FLUSH : RUN;
                        if (pend_n)
                            flush_n = 2'(FLUSH_DEPTH);
                    end
                end
                FLUSH: begin
                    if (wait_req) begin
                        pipe_freeze_out     = 1'b1;
                        pc_write_enable_out = 1'b0;
                        if_id_enable_out    = 1'b0;
                        state_n             = MEM_WAIT;
                    end else begin
                        if_id_flush_out  = 1'b1;
                        id_ex_bubble_out = 1'b1;
                        pc_redirect_out  = pend || branch_taken_in;
                        redirect_pc_out  = pend ? pend_pc : branch_taken_in ? branch_target_in : '0;
                        pend_n           = 1'b0;
                        flush_n          = (branch_taken_in && !pend) ? 2'(FLUSH_DEPTH - 1) : flush_cnt - 2'd1;
                        state_n          = flush_n == 2'd0 ? RUN : FLUSH;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            flush_cnt       <= '0;
            pend            <= 1'b0;
            pend_pc         <= '0;
            mem_timeout_out <= 1'b0;
        end else begin
            state           <= state_n;
            flush_cnt       <= flush_n;
            pend            <= pend_n;
            pend_pc         <= pend_pc_n;
            mem_timeout_out <= mem_timeout_out | timeout_hit;
        end
    end

    sat_counter #(.WIDTH(WAIT_W)) u_wait (
        .clk   (clk),
        .rst   (rst),
        .en    (pipe_freeze_out),
        .clr   (!pipe_freeze_out),
        .count (wait_cnt)
    );

    sat_counter #(.WIDTH(PERF_WIDTH)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .en    (!pc_write_enable_out || state == FLUSH),
        .clr   (1'b0),
        .count (stall_cycles_out)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed checks of stall, flush, memory wait, timeout and reset behaviour
module tb_pipeline_sequencer;
    import pipeline_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0, branch = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    addr_t       target = '0;
    logic        pc_we, if_id_en, if_id_flush, bubble, freeze, redir, timeout;
    addr_t       redir_pc;
    logic [15:0] stall;
    logic [5:0]  ctl;
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.FLUSH_DEPTH(2), .MEM_TIMEOUT(4), .PERF_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .hazard_stall_in     (hazard),
        .branch_taken_in     (branch),
        .branch_target_in    (target),
        .mem_req_in          (mem_req),
        .mem_ready_in        (mem_ready),
        .pc_write_enable_out (pc_we),
        .if_id_enable_out    (if_id_en),
        .if_id_flush_out     (if_id_flush),
        .id_ex_bubble_out    (bubble),
        .pipe_freeze_out     (freeze),
        .pc_redirect_out     (redir),
        .redirect_pc_out     (redir_pc),
        .mem_timeout_out     (timeout),
        .stall_cycles_out    (stall)
    );

    // {pc_we, if_id_en, flush, bubble, freeze, redirect}
    assign ctl = {pc_we, if_id_en, if_id_flush, bubble, freeze, redir};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic h, input logic b, input logic mr, input logic rd, input addr_t t);
        hazard = h;
        branch = b;
        mem_req = mr;
        mem_ready = rd;
        target = t;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(0, 0, 0, 0, '0);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctl", 32'(ctl), 32'h30);
        check("reset_redir_pc", redir_pc, 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);

        // load-use stall
        do_reset();
        drive(1, 0, 0, 0, '0);
        @(negedge clk); check("lu_ctl", 32'(ctl), 32'h04);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("lu_after_ctl", 32'(ctl), 32'h30);
        check("lu_stall_cnt", 32'(stall), 32'd1);

        // branch with a simultaneous hazard: redirect wins
        do_reset();
        drive(1, 1, 0, 0, 32'h0000_0100);
        @(negedge clk); check("br_ctl", 32'(ctl), 32'h3D);
        check("br_pc", redir_pc, 32'h0000_0100);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("br_flush2_ctl", 32'(ctl), 32'h3C);
        next_cycle();
        @(negedge clk); check("br_run_ctl", 32'(ctl), 32'h30);
        check("br_stall_cnt", 32'(stall), 32'd1);

        // second branch during FLUSH restarts the redirect and count
        do_reset();
        drive(0, 1, 0, 0, 32'h100);
        @(negedge clk);
        next_cycle(); drive(0, 1, 0, 0, 32'h80);
        @(negedge clk); check("rst_br_ctl", 32'(ctl), 32'h3D);
        check("rst_br_pc", redir_pc, 32'h80);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("rst_br_flush_ctl", 32'(ctl), 32'h3C);
        next_cycle();
        @(negedge clk); check("rst_br_run_ctl", 32'(ctl), 32'h30);

        // memory wait of three cycles
        do_reset();
        drive(0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check($sformatf("mw_freeze%0d", i), 32'(ctl), 32'h02);
            next_cycle();
        end
        drive(0, 0, 1, 1, '0);
        @(negedge clk); check("mw_ready_ctl", 32'(ctl), 32'h30);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("mw_stall_cnt", 32'(stall), 32'd3);
        check("mw_no_timeout", 32'(timeout), 32'h0);

        // branch during memory wait: redirect only on first FLUSH cycle, first target kept
        do_reset();
        drive(0, 0, 1, 0, '0);
        @(negedge clk); check("bmw_entry_ctl", 32'(ctl), 32'h02);
        next_cycle(); drive(0, 1, 1, 0, 32'h200);
        @(negedge clk); check("bmw_w1_ctl", 32'(ctl), 32'h02);
        next_cycle(); drive(0, 1, 1, 0, 32'h300);
        @(negedge clk); check("bmw_w2_ctl", 32'(ctl), 32'h02);
        next_cycle(); drive(0, 0, 1, 1, '0);
        @(negedge clk); check("bmw_ready_ctl", 32'(ctl), 32'h30);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("bmw_redir_ctl", 32'(ctl), 32'h3D);
        check("bmw_redir_pc", redir_pc, 32'h200);
        next_cycle();
        @(negedge clk); check("bmw_flush2_ctl", 32'(ctl), 32'h3C);
        next_cycle();
        @(negedge clk); check("bmw_run_ctl", 32'(ctl), 32'h30);

        // memory wait inside FLUSH resumes the remaining flush afterwards
        do_reset();
        drive(0, 1, 0, 0, 32'h100);
        @(negedge clk);
        next_cycle(); drive(0, 0, 1, 0, '0);
        @(negedge clk); check("fmw_freeze_ctl", 32'(ctl), 32'h02);
        next_cycle(); drive(0, 0, 1, 1, '0);
        @(negedge clk); check("fmw_ready_ctl", 32'(ctl), 32'h30);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("fmw_resume_ctl", 32'(ctl), 32'h3C);
        next_cycle();
        @(negedge clk); check("fmw_run_ctl", 32'(ctl), 32'h30);

        // timeout after four wait cycles, sticky until reset
        do_reset();
        drive(0, 0, 1, 0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check($sformatf("to_low%0d", i), 32'(timeout), 32'h0);
            next_cycle();
        end
        @(negedge clk); check("to_set", 32'(timeout), 32'h1);
        check("to_still_frozen", 32'(ctl), 32'h02);
        next_cycle(); drive(0, 0, 1, 1, '0);
        @(negedge clk);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("to_sticky", 32'(timeout), 32'h1);
        check("to_run_ctl", 32'(ctl), 32'h30);
        do_reset();
        @(negedge clk); check("to_cleared", 32'(timeout), 32'h0);

        // asynchronous reset in the middle of FLUSH
        do_reset();
        drive(1, 0, 0, 0, '0);
        @(negedge clk);
        next_cycle(); drive(0, 1, 0, 0, 32'h40);
        @(negedge clk);
        next_cycle(); drive(0, 0, 0, 0, '0);
        @(negedge clk); check("ar_in_flush", 32'(ctl), 32'h3C);
        check("ar_stall_before", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_ctl", 32'(ctl), 32'h30);
        check("ar_stall", 32'(stall), 32'h0);
        next_cycle(); rst = 1'b0;
        @(negedge clk); check("ar_run_ctl", 32'(ctl), 32'h30);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
